sd_host_cmd: RTL and testbench

SD_HOST_CMD -- requirements
Module: sd_host_cmd

---
 rtl/sd_host_cmd.sv | 201 ++++++++++++++++++++
 tb/tb_sd_host_cmd.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_host_cmd.sv
// SD card CMD-line host: divides clk_50 into sd_clk, shifts out a 48-bit command
// frame with CRC7 and captures an optional 48- or 136-bit response.
module sd_host_cmd #(
    parameter int CLK_DIV = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         clk_50,
    input  logic         reset,
    output logic         sd_clk,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_t,
    input  logic         cmd_go,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         cmd_busy,
    output logic         cmd_done,
    output logic [135:0] resp_out,
    output logic         err_timeout,
    output logic         err_crc
);

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX, NCC, DONE} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);

    state_t         r_state;
    state_t         w_nextState;
    logic [15:0]    r_divCnt;
    logic           r_sdClk;
    logic           r_cmdO;
    logic           r_cmdT;
    logic [47:0]    r_frame;
    logic [1:0]     r_type;
    logic [15:0]    r_cnt;
    logic [135:0]   r_resp;
    logic           r_errTo;
    logic           r_errCrc;
    logic           w_rise;
    logic           w_fall;
    logic [39:0]    w_txHead;
    logic [47:0]    w_txFrame;
    logic [135:0]   w_nextResp;
    logic [15:0]    w_rxLast;
    logic           w_crcBad;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_divCnt <= '0;
            r_sdClk  <= 1'b0;
        end else if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
            r_sdClk  <= ~r_sdClk;
        end else begin
            r_divCnt <= r_divCnt + 16'd1;
        end
    end

    // Strobes fire in the clk_50 cycle whose edge toggles sd_clk.
    assign w_rise     = (r_divCnt == DIV_LAST) && !r_sdClk;
    assign w_fall     = (r_divCnt == DIV_LAST) && r_sdClk;
    assign w_txHead   = {2'b01, cmd_index, cmd_arg};
    assign w_txFrame  = {w_txHead, crc7(w_txHead), 1'b1};
    assign w_nextResp = {r_resp[134:0], sd_cmd_i};
    assign w_rxLast   = (r_type == 2'd3) ? 16'd135 : 16'd47;
    assign w_crcBad   = (r_type == 2'd1) && (crc7(w_nextResp[47:8]) != w_nextResp[7:1]);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        cmd_busy    = 1'b0;
        cmd_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_go) w_nextState = TX;
            end
            TX: begin
                cmd_busy = 1'b1;
                if (w_fall && r_cnt == 16'd48) w_nextState = (r_type == 2'd0) ? NCC : WAIT;
            end
            WAIT: begin
                cmd_busy = 1'b1;
                if (w_rise) begin
                    if (!sd_cmd_i)              w_nextState = RX;
                    else if (r_cnt == NCR_LAST) w_nextState = NCC;
                end
            end
            RX: begin
                cmd_busy = 1'b1;
                if (w_rise && r_cnt == w_rxLast) w_nextState = NCC;
            end
            NCC: begin
                cmd_busy = 1'b1;
                if (w_rise && r_cnt == 16'd7) w_nextState = DONE;
            end
            DONE: begin
                cmd_busy    = 1'b1;
                cmd_done    = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // r_cnt is shared: TX bit index, WAIT Ncr count, RX bits held, NCC rises.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_cmdO   <= 1'b1;
            r_cmdT   <= 1'b1;
            r_frame  <= '0;
            r_type   <= '0;
            r_cnt    <= '0;
            r_resp   <= '0;
            r_errTo  <= 1'b0;
            r_errCrc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_go) begin
                        r_frame  <= w_txFrame;
                        r_type   <= resp_type;
                        r_resp   <= '0;
                        r_errTo  <= 1'b0;
                        r_errCrc <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                TX: begin
                    if (w_fall) begin
                        if (r_cnt == 16'd48) begin
                            r_cmdT <= 1'b1;
                            r_cmdO <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cmdT  <= 1'b0;
                            r_cmdO  <= r_frame[47];
                            r_frame <= {r_frame[46:0], 1'b0};
                            r_cnt   <= r_cnt + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (w_rise) begin
                        if (!sd_cmd_i) begin
                            r_resp <= w_nextResp;
                            r_cnt  <= 16'd1;
                        end else if (r_cnt == NCR_LAST) begin
                            r_errTo <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                RX: begin
                    if (w_rise) begin
                        r_resp <= w_nextResp;
                        if (r_cnt == w_rxLast) begin
                            r_cnt    <= '0;
                            r_errCrc <= w_crcBad;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                NCC: begin
                    if (w_rise) r_cnt <= (r_cnt == 16'd7) ? 16'd0 : r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign sd_clk      = r_sdClk;
    assign sd_cmd_o    = r_cmdO;
    assign sd_cmd_t    = r_cmdT;
    assign resp_out    = r_resp;
    assign err_timeout = r_errTo;
    assign err_crc     = r_errCrc;

endmodule

// File: tb/tb_sd_host_cmd.sv
// Self-checking bench for sd_host_cmd: three instances (CLK_DIV 2, 1, 5) driven by
// a card model, checked against frame/response rules computed in the bench.
module tb_sd_host_cmd;

    localparam int NCR = 64;

    typedef struct {
        int           d;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rt;
        int           delay;
        bit           silent;
        bit           midGo;
        logic [135:0] pattern;
        logic [47:0]  expFrame;
        logic [135:0] expResp;
        logic         expTo;
        logic         expCrc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         sdClk    [3];
    logic         sdCmdI   [3];
    logic         sdCmdO   [3];
    logic         sdCmdT   [3];
    logic         cmdGo    [3];
    logic [5:0]   cmdIndex [3];
    logic [31:0]  cmdArg   [3];
    logic [1:0]   respType [3];
    logic         cmdBusy  [3];
    logic         cmdDone  [3];
    logic [135:0] respOut  [3];
    logic         errTo    [3];
    logic         errCrc   [3];
    int           divOf    [3] = '{2, 1, 5};

    for (genvar g = 0; g < 3; g++) begin : gDut
        sd_host_cmd #(.CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 5)), .NCR_MAX(NCR)) uDut (
            .clk_50(clk), .reset(reset), .sd_clk(sdClk[g]), .sd_cmd_i(sdCmdI[g]),
            .sd_cmd_o(sdCmdO[g]), .sd_cmd_t(sdCmdT[g]), .cmd_go(cmdGo[g]),
            .cmd_index(cmdIndex[g]), .cmd_arg(cmdArg[g]), .resp_type(respType[g]),
            .cmd_busy(cmdBusy[g]), .cmd_done(cmdDone[g]), .resp_out(respOut[g]),
            .err_timeout(errTo[g]), .err_crc(errCrc[g]));
    end

    int           nChecks = 0;
    int           nPass   = 0;
    logic [47:0]  obsFrame;
    int           obsTx;
    int           obsRises;
    bit           obsViol;
    bit           obsDone;
    logic [135:0] obsResp;
    logic         obsTo;
    logic         obsCrc;

    // Remainder of (message * x^7) modulo x^7+x^3+1 by long division.
    function automatic logic [6:0] crcRef(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    function automatic logic [47:0] mkFrame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crcRef(h), 1'b1};
    endfunction

    function automatic int lenOf(input logic [1:0] rt);
        return (rt == 2'd3) ? 136 : 48;
    endfunction

    function automatic int expRises(input logic [1:0] rt, input bit silent, input int delay);
        if (rt == 2'd0) return 8;
        if (silent) return NCR + 8;
        return delay + lenOf(rt) + 8;
    endfunction

    function automatic logic cardBit(input int p, input int delay, input bit silent,
                                     input logic [135:0] pat, input int len);
        if (silent || p < delay) return 1'b1;
        if (p - delay < len) return pat[len - 1 - (p - delay)];
        return 1'b1;
    endfunction

    function automatic vec_t mkVec(input int d, input logic [5:0] idx, input logic [31:0] arg,
                                   input logic [1:0] rt, input int delay, input bit silent,
                                   input bit midGo, input logic [135:0] pat,
                                   input logic [47:0] frame, input logic [135:0] resp,
                                   input logic to, input logic crc);
        vec_t v;
        v.d = d; v.idx = idx; v.arg = arg; v.rt = rt; v.delay = delay; v.silent = silent;
        v.midGo = midGo; v.pattern = pat; v.expFrame = frame; v.expResp = resp;
        v.expTo = to; v.expCrc = crc;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input string what,
                               input logic [135:0] act, input logic [135:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, what, act, exp);
    endtask

    task automatic applyStimulus(input int d, input logic [5:0] idx, input logic [31:0] arg,
                                 input logic [1:0] rt, input string tag);
        @(negedge clk);
        cmdIndex[d] = idx; cmdArg[d] = arg; respType[d] = rt;
        cmdGo[d] = 1'b1; sdCmdI[d] = 1'b1;
        @(negedge clk);
        cmdGo[d] = 1'b0; cmdIndex[d] = ~idx; cmdArg[d] = ~arg; respType[d] = ~rt;
        checkOutput(tag, "busy_after_go", 136'(cmdBusy[d]), 136'd1);
    endtask

    // Watches host line activity and plays the card until cmd_done or budget expiry.
    task automatic serviceCmd(input int d, input int delay, input bit silent,
                              input logic [135:0] pat, input int len, input bit midGo);
        logic prevClk, prevO, prevT, rose, fell;
        bit   released, midSent, midClr;
        int   seqIdx, rises;
        obsFrame = '0; obsTx = 0; obsViol = 0; obsDone = 0;
        prevClk = sdClk[d]; prevO = sdCmdO[d]; prevT = sdCmdT[d];
        released = 0; midSent = 0; midClr = 0; seqIdx = 0; rises = 0;
        for (int c = 0; c < 20000 && !obsDone; c++) begin
            @(negedge clk);
            if (midClr) begin cmdGo[d] = 1'b0; midClr = 0; end
            rose = !prevClk && sdClk[d];
            fell = prevClk && !sdClk[d];
            if ((sdCmdO[d] !== prevO || sdCmdT[d] !== prevT) && !fell) obsViol = 1;
            if (!cmdDone[d] && !cmdBusy[d]) obsViol = 1;
            if (!released && rose && sdCmdT[d] == 1'b0) begin
                obsFrame = {obsFrame[46:0], sdCmdO[d]};
                obsTx++;
            end
            if (!released && fell && prevT == 1'b0 && sdCmdT[d] == 1'b1) released = 1;
            if (released) begin
                if (sdCmdT[d] == 1'b0) obsViol = 1;
                if (rose) rises++;
                if (fell) begin
                    sdCmdI[d] = cardBit(seqIdx, delay, silent, pat, len);
                    seqIdx++;
                end
                if (midGo && !midSent && seqIdx == delay + 40) begin
                    cmdIndex[d] = 6'h3F; cmdArg[d] = $urandom; respType[d] = 2'd0;
                    cmdGo[d] = 1'b1; midSent = 1; midClr = 1;
                end
            end else if (fell) begin
                sdCmdI[d] = 1'($urandom_range(0, 1));
            end
            if (cmdDone[d]) begin
                obsDone = 1; obsRises = rises; obsResp = respOut[d];
                obsTo = errTo[d]; obsCrc = errCrc[d];
            end
            prevClk = sdClk[d]; prevO = sdCmdO[d]; prevT = sdCmdT[d];
        end
        if (midClr) cmdGo[d] = 1'b0;
        sdCmdI[d] = 1'b1;
    endtask

    task automatic checkCmd(input string tag, input vec_t v);
        checkOutput(tag, "done_seen", 136'(obsDone), 136'd1);
        if (obsDone) begin
            checkOutput(tag, "tx_bits", 136'(obsTx), 136'd48);
            checkOutput(tag, "frame", 136'(obsFrame), 136'(v.expFrame));
            checkOutput(tag, "resp_out", obsResp, v.expResp);
            checkOutput(tag, "err_timeout", 136'(obsTo), 136'(v.expTo));
            checkOutput(tag, "err_crc", 136'(obsCrc), 136'(v.expCrc));
            checkOutput(tag, "rises_to_done", 136'(obsRises), 136'(expRises(v.rt, v.silent, v.delay)));
            checkOutput(tag, "line_discipline", 136'(obsViol), 136'd0);
        end
    endtask

    task automatic finishCmd(input string tag, input int d);
        @(negedge clk);
        checkOutput(tag, "done_pulse", 136'(cmdDone[d]), 136'd0);
        checkOutput(tag, "idle_busy", 136'(cmdBusy[d]), 136'd0);
    endtask

    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v.d, v.idx, v.arg, v.rt, tag);
        serviceCmd(v.d, v.delay, v.silent, v.pattern, lenOf(v.rt), v.midGo);
        checkCmd(tag, v);
        finishCmd(tag, v.d);
    endtask

    task automatic resetMidTx(input int d, input string tag);
        logic prevClk;
        int   n, k;
        bit   doneSeen;
        applyStimulus(d, 6'd8, 32'h1AA, 2'd1, tag);
        n = 0;
        prevClk = sdClk[d];
        for (int c = 0; c < 5000 && n < 20; c++) begin
            @(negedge clk);
            if (!prevClk && sdClk[d] && !sdCmdT[d]) n++;
            prevClk = sdClk[d];
        end
        checkOutput(tag, "reached_bit20", 136'(n), 136'd20);
        checkOutput(tag, "driving_before_reset", 136'(sdCmdT[d]), 136'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput(tag, "cmd_t_released", 136'(sdCmdT[d]), 136'd1);
        checkOutput(tag, "cmd_o_reset", 136'(sdCmdO[d]), 136'd1);
        checkOutput(tag, "busy_reset", 136'(cmdBusy[d]), 136'd0);
        checkOutput(tag, "sd_clk_reset", 136'(sdClk[d]), 136'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        doneSeen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (cmdDone[d]) doneSeen = 1;
            if (k == 0 && sdClk[d]) k = c;
        end
        checkOutput(tag, "first_rise_cycles", 136'(k), 136'(divOf[d]));
        checkOutput(tag, "no_done_after_abort", 136'(doneSeen), 136'd0);
    endtask

    vec_t vecs [6];

    initial begin
        vec_t         v;
        logic [159:0] wide;
        logic [63:0]  w64;
        logic [39:0]  head;
        logic [135:0] pat;
        logic [135:0] p136;

        p136 = 136'h3F0123456789ABCDEF0F1E2D3C4B5A6979;
        vecs[0] = mkVec(0, 6'd0, 32'h0, 2'd0, 0, 1, 0, '0, 48'h400000000095, '0, 0, 0);
        vecs[1] = mkVec(0, 6'd8, 32'h1AA, 2'd1, 2, 0, 0, 136'h08000001AA13,
                        48'h48000001AA87, 136'h08000001AA13, 0, 0);
        vecs[2] = mkVec(0, 6'd8, 32'h1AA, 2'd1, 2, 0, 0, 136'h08000001AA15,
                        48'h48000001AA87, 136'h08000001AA15, 0, 1);
        vecs[3] = mkVec(0, 6'd8, 32'h1AA, 2'd1, 0, 1, 0, '0, 48'h48000001AA87, '0, 1, 0);
        vecs[4] = mkVec(0, 6'd41, 32'h1AA, 2'd2, 3, 0, 0, 136'h08000001AA15,
                        mkFrame(6'd41, 32'h1AA), 136'h08000001AA15, 0, 0);
        vecs[5] = mkVec(0, 6'd2, 32'h0, 2'd3, 1, 0, 1, p136, mkFrame(6'd2, 32'h0), p136, 0, 0);

        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            cmdGo[g] = 1'b0; cmdIndex[g] = '0; cmdArg[g] = '0; respType[g] = '0; sdCmdI[g] = 1'b1;
        end
        #1;
        checkOutput("reset", "sd_clk", 136'(sdClk[0]), 136'd0);
        checkOutput("reset", "cmd_o", 136'(sdCmdO[0]), 136'd1);
        checkOutput("reset", "cmd_t", 136'(sdCmdT[0]), 136'd1);
        checkOutput("reset", "busy", 136'(cmdBusy[0]), 136'd0);
        checkOutput("reset", "done", 136'(cmdDone[0]), 136'd0);
        checkOutput("reset", "resp_out", respOut[0], 136'd0);
        checkOutput("reset", "errors", {134'd0, errTo[0], errCrc[0]}, 136'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) runVec($sformatf("vec%0d", i), vecs[i]);

        // cmd_go held through DONE must be accepted one cycle later, from IDLE.
        v = vecs[0];
        applyStimulus(0, v.idx, v.arg, v.rt, "go_at_done");
        serviceCmd(0, v.delay, v.silent, v.pattern, lenOf(v.rt), 0);
        checkCmd("go_at_done.first", v);
        cmdIndex[0] = 6'd8; cmdArg[0] = 32'h1AA; respType[0] = 2'd1; cmdGo[0] = 1'b1;
        finishCmd("go_at_done", 0);
        @(negedge clk);
        checkOutput("go_at_done", "busy_second", 136'(cmdBusy[0]), 136'd1);
        cmdGo[0] = 1'b0;
        serviceCmd(0, 2, 0, 136'h08000001AA13, 48, 0);
        checkCmd("go_at_done.second", vecs[1]);
        finishCmd("go_at_done.second", 0);

        for (int d = 1; d < 3; d++) begin
            resetMidTx(d, $sformatf("reset_div%0d", divOf[d]));
            v = vecs[1];
            v.d = d;
            runVec($sformatf("after_reset_div%0d", divOf[d]), v);
        end

        for (int n = 0; n < 24; n++) begin
            v.d = $urandom_range(0, 2);
            v.idx = 6'($urandom_range(0, 63));
            v.arg = $urandom;
            v.rt = 2'($urandom_range(0, 3));
            v.delay = $urandom_range(0, 20);
            v.silent = (v.rt != 2'd0) && ($urandom_range(0, 7) == 0);
            v.midGo = ($urandom_range(0, 3) == 0);
            if (v.rt == 2'd3) begin
                wide = {$urandom, $urandom, $urandom, $urandom, $urandom};
                pat = wide[135:0];
                pat[135] = 1'b0;
            end else begin
                w64 = {$urandom, $urandom};
                head = w64[39:0];
                head[39] = 1'b0;
                pat = '0;
                if (v.rt == 2'd1 && $urandom_range(0, 1) == 1)
                    pat[47:0] = {head, crcRef(head), 1'b1};
                else
                    pat[47:0] = {head, 7'($urandom_range(0, 127)), 1'b1};
            end
            v.pattern = pat;
            v.expFrame = mkFrame(v.idx, v.arg);
            v.expResp = (v.silent || v.rt == 2'd0) ? 136'd0 : pat;
            v.expTo = v.silent;
            v.expCrc = !v.silent && v.rt == 2'd1 && (crcRef(pat[47:8]) != pat[7:1]);
            runVec($sformatf("rand%0d", n), v);
        end

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
